// File: rtl/ber_pkg.sv
// ber_pkg
//   Shared definitions for the BER measurement controller:
//     ber_state_t  measurement sequencer states
//     BYTE_W       width of the compared data words
//     sat_add      unsigned add that clamps at the all-ones value of a given width
package ber_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } ber_state_t;

    localparam int BYTE_W = 8;

    // Adds two values and clamps the result at (2**w)-1. Callers pass their own
    // register width in w and truncate the 64-bit result back to that width.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [63:0] max;
        max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max})
            sat_add = max;
        else
            sat_add = sum[63:0];
    endfunction

endpackage

// File: rtl/ber_popcount8.sv
// ber_popcount8
//   Combinational bit-error count for one byte: popcount(rx_data ^ ref_data).
//   Ports:
//     rx_data   in  8  received byte
//     ref_data  in  8  reference pattern byte
//     count     out 4  number of differing bits (0..8)
module ber_popcount8
    import ber_pkg::*;
(
    input  logic [BYTE_W-1:0] rx_data,
    input  logic [BYTE_W-1:0] ref_data,
    output logic [3:0]        count
);

    logic [BYTE_W-1:0] diff;

    assign diff = rx_data ^ ref_data;

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < BYTE_W; i++)
            count = count + {3'd0, diff[i]};
    end

endmodule

// File: rtl/ber_test_ctrl.sv
// ber_test_ctrl
//   Sequences one bit-error-ratio measurement: waits for a run of error-free
//   words (pattern sync), then accumulates compared bits and bit errors over a
//   programmed number of words. All accumulators saturate.
//   Optional feature macro: BER_RESYNC_EN -- loss-of-sync detection in MEASURE
//   (LOSS_WORDS consecutive words with >= RESYNC_THR bit errors force a resync).
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     start_i          begin a measurement (IDLE/DONE only)
//     abort_i          return to IDLE from any state, results held
//     window_words_i   words per measurement, sampled on start (0 means 1)
//     rx_valid_i       rx_data_i/ref_data_i valid
//     rx_data_i        received byte
//     ref_data_i       reference byte
//     busy_o           in SYNC or MEASURE
//     done_o           in DONE
//     sync_fail_o      sync was not reached within SYNC_TIMEOUT words
//     total_bits_o     bits compared during MEASURE
//     total_errors_o   bit errors seen during MEASURE
//     resync_cnt_o     number of resync events (0 without BER_RESYNC_EN)
module ber_test_ctrl
    import ber_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int WIN_W        = 24,
    parameter int SYNC_WORDS   = 16,
    parameter int SYNC_TIMEOUT = 4096,
    parameter int RESYNC_THR   = 3,
    parameter int LOSS_WORDS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WIN_W-1:0]  window_words_i,
    input  logic              rx_valid_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    input  logic [BYTE_W-1:0] ref_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sync_fail_o,
    output logic [CNT_W-1:0]  total_bits_o,
    output logic [CNT_W-1:0]  total_errors_o,
    output logic [7:0]        resync_cnt_o
);

    localparam int RUN_W = $clog2(SYNC_WORDS + 1);
    localparam int TMO_W = $clog2(SYNC_TIMEOUT + 1);
    localparam int BAD_W = $clog2(LOSS_WORDS + 1);

`ifdef BER_RESYNC_EN
    localparam bit RESYNC_EN = 1'b1;
`else
    localparam bit RESYNC_EN = 1'b0;
`endif

    ber_state_t         state;
    ber_state_t         state_nxt;
    logic [3:0]         err_p0;
    logic               vld_p1;
    logic [3:0]         err_p1;
    logic [RUN_W-1:0]   run_cnt;
    logic [TMO_W-1:0]   sync_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [WIN_W-1:0]   window;
    logic [BAD_W-1:0]   bad_cnt;
    logic               busy;
    logic               start_ok;
    logic               bad_word;
    logic               sync_hit;
    logic               tmo_hit;
    logic               win_hit;
    logic               loss_hit;

    assign busy     = (state == SYNC) || (state == MEASURE);
    assign busy_o   = busy;
    assign done_o   = (state == DONE);
    assign start_ok = start_i && !abort_i && ((state == IDLE) || (state == DONE));

    // ---- stage 0: xor + popcount of the incoming byte pair ----
    ber_popcount8 u_popcount (
        .rx_data  (rx_data_i),
        .ref_data (ref_data_i),
        .count    (err_p0)
    );

    // ---- stage 1: register word valid and error count ----
    // Valid only while a measurement is running; an abort kills the word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= rx_valid_i && busy && !abort_i;
    end

    always_ff @(posedge clk) begin
        err_p1 <= err_p0;
    end

    // ---- stage 2: sequencer and accumulators act on the registered word ----
    // The run counter is tested before its increment, so reaching SYNC_WORDS
    // and leaving SYNC happen on the same edge (that word is not measured).
    assign sync_hit = vld_p1 && (err_p1 == 4'd0) &&
                      (run_cnt == RUN_W'(SYNC_WORDS - 1));
    assign tmo_hit  = vld_p1 && (sync_cnt == TMO_W'(SYNC_TIMEOUT - 1));
    assign win_hit  = vld_p1 && (win_cnt == window - WIN_W'(1));
    assign bad_word = (err_p1 >= 4'(RESYNC_THR));
    assign loss_hit = RESYNC_EN && vld_p1 && bad_word &&
                      (bad_cnt == BAD_W'(LOSS_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start_i) state_nxt = SYNC;
                SYNC: begin
                    if (sync_hit)
                        state_nxt = MEASURE;
                    else if (tmo_hit)
                        state_nxt = DONE;
                end
                MEASURE: begin
                    // Window end wins over a simultaneous loss of sync.
                    if (win_hit)
                        state_nxt = DONE;
                    else if (loss_hit)
                        state_nxt = SYNC;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt        <= '0;
            sync_cnt       <= '0;
            win_cnt        <= '0;
            window         <= '0;
            bad_cnt        <= '0;
            sync_fail_o    <= 1'b0;
            total_bits_o   <= '0;
            total_errors_o <= '0;
        end else if (start_ok) begin
            run_cnt        <= '0;
            sync_cnt       <= '0;
            win_cnt        <= '0;
            bad_cnt        <= '0;
            sync_fail_o    <= 1'b0;
            total_bits_o   <= '0;
            total_errors_o <= '0;
            window         <= (window_words_i == '0) ? WIN_W'(1) : window_words_i;
        end else if (!abort_i && vld_p1) begin
            if (state == SYNC) begin
                if (sync_hit) begin
                    run_cnt  <= '0;
                    sync_cnt <= '0;
                    bad_cnt  <= '0;
                end else begin
                    run_cnt  <= (err_p1 == 4'd0) ? run_cnt + RUN_W'(1) : '0;
                    sync_cnt <= sync_cnt + TMO_W'(1);
                    if (tmo_hit)
                        sync_fail_o <= 1'b1;
                end
            end else if (state == MEASURE) begin
                total_bits_o   <= CNT_W'(sat_add(64'(total_bits_o), 64'(BYTE_W), CNT_W));
                total_errors_o <= CNT_W'(sat_add(64'(total_errors_o), 64'(err_p1), CNT_W));
                win_cnt        <= win_cnt + WIN_W'(1);
                if (loss_hit)
                    bad_cnt <= '0;
                else
                    bad_cnt <= bad_word ? bad_cnt + BAD_W'(1) : '0;
            end
        end
    end

`ifdef BER_RESYNC_EN
    logic [7:0] resync_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            resync_cnt <= 8'd0;
        else if (start_ok)
            resync_cnt <= 8'd0;
        else if ((state == MEASURE) && (state_nxt == SYNC))
            resync_cnt <= 8'(sat_add(64'(resync_cnt), 64'd1, 8));
    end

    assign resync_cnt_o = resync_cnt;
`else
    assign resync_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_ber_test_ctrl.sv
module tb_ber_test_ctrl;

    localparam int SW  = 16;   // sync words
    localparam int TMO = 64;   // sync timeout used by both instances

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [23:0] window_words_i = '0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic [7:0]  ref_data_i = '0;

    logic        a_busy, a_done, a_sf, b_busy, b_done, b_sf;
    logic [31:0] a_bits, a_errs;
    logic [7:0]  b_bits, b_errs, a_rs, b_rs;

    always #5 clk = ~clk;

    ber_test_ctrl #(.CNT_W(32), .WIN_W(24), .SYNC_WORDS(SW), .SYNC_TIMEOUT(TMO),
                    .RESYNC_THR(3), .LOSS_WORDS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .window_words_i(window_words_i), .rx_valid_i(rx_valid_i),
        .rx_data_i(rx_data_i), .ref_data_i(ref_data_i),
        .busy_o(a_busy), .done_o(a_done), .sync_fail_o(a_sf),
        .total_bits_o(a_bits), .total_errors_o(a_errs), .resync_cnt_o(a_rs));

    ber_test_ctrl #(.CNT_W(8), .WIN_W(24), .SYNC_WORDS(SW), .SYNC_TIMEOUT(TMO),
                    .RESYNC_THR(3), .LOSS_WORDS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .window_words_i(window_words_i), .rx_valid_i(rx_valid_i),
        .rx_data_i(rx_data_i), .ref_data_i(ref_data_i),
        .busy_o(b_busy), .done_o(b_done), .sync_fail_o(b_sf),
        .total_bits_o(b_bits), .total_errors_o(b_errs), .resync_cnt_o(b_rs));

    int ncmp = 0;
    int nfail = 0;

    logic [7:0] ref_q[$];
    logic [7:0] mask_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: walks the list of per-word error counts as the
    // measurement would see them and reports the final results.
    function automatic void model(input int e[$], input int n, input int win, input int cw,
                                  output longint bits, output longint errs,
                                  output bit sf, output int rs, output bit dn);
        int run = 0, scnt = 0, wcnt = 0, bad = 0;
        bit meas = 0;
        longint mx = (longint'(1) << cw) - 1;
        bits = 0; errs = 0; sf = 0; rs = 0; dn = 0;
        if (win == 0) win = 1;
        for (int i = 0; i < n && !dn; i++) begin
            if (!meas) begin
                scnt++;
                run = (e[i] == 0) ? run + 1 : 0;
                if (run == SW) begin
                    meas = 1; bad = 0;
                end else if (scnt == TMO) begin
                    sf = 1; dn = 1;
                end
            end else begin
                bits = (bits + 8 > mx) ? mx : bits + 8;
                errs = (errs + e[i] > mx) ? mx : errs + e[i];
                wcnt++;
                if (wcnt == win) dn = 1;
`ifdef BER_RESYNC_EN
                else begin
                    bad = (e[i] >= 3) ? bad + 1 : 0;
                    if (bad == 4) begin
                        meas = 0; run = 0; scnt = 0; bad = 0;
                        rs = (rs < 255) ? rs + 1 : 255;
                    end
                end
`endif
            end
        end
    endfunction

    // mode 0: fixed mask; mode 1: random mostly-clean mask
    task automatic add(input int n, input logic [7:0] mask, input int mode);
        for (int i = 0; i < n; i++) begin
            ref_q.push_back(8'($urandom));
            if (mode == 1)
                mask_q.push_back(($urandom_range(0, 9) < 7) ? 8'd0 : 8'($urandom_range(1, 255)));
            else
                mask_q.push_back(mask);
        end
    endtask

    task automatic start_run(input int win);
        start_i = 1'b1;
        window_words_i = 24'(win);
        @(negedge clk);
        start_i = 1'b0;
        chk("start_busy", a_busy, 1);
        chk("start_sf_clear", a_sf, 0);
        chk("start_bits_clear", b_bits, 0);
    endtask

    task automatic feed(input int start_at);
        for (int i = 0; i < ref_q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx_valid_i = 1'b0;
                rx_data_i  = 8'($urandom);
                ref_data_i = 8'($urandom);
                start_i    = 1'b0;
                @(negedge clk);
            end
            rx_valid_i = 1'b1;
            ref_data_i = ref_q[i];
            rx_data_i  = ref_q[i] ^ mask_q[i];
            start_i    = (i == start_at);
            @(negedge clk);
        end
        rx_valid_i = 1'b0;
        start_i    = 1'b0;
    endtask

    task automatic check_results(input string tag, input int n, input int win, input bit aborted);
        int e[$];
        longint bits32, errs32, bits8, errs8;
        bit sf, dn;
        int rs;
        foreach (mask_q[i]) e.push_back($countones(mask_q[i]));
        model(e, n, win, 32, bits32, errs32, sf, rs, dn);
        model(e, n, win, 8, bits8, errs8, sf, rs, dn);
        chk({tag, "_done"}, a_done, (dn && !aborted) ? 1 : 0);
        chk({tag, "_busy"}, b_busy, (!dn && !aborted) ? 1 : 0);
        chk({tag, "_sf"}, a_sf, sf);
        chk({tag, "_bits32"}, a_bits, bits32);
        chk({tag, "_errs32"}, a_errs, errs32);
        chk({tag, "_bits8"}, b_bits, bits8);
        chk({tag, "_errs8"}, b_errs, errs8);
        chk({tag, "_resync"}, a_rs, rs);
    endtask

    task automatic run_case(input string tag, input int win, input int start_at);
        start_run(win);
        feed(start_at);
        repeat (3) @(negedge clk);
        check_results(tag, ref_q.size(), win, 0);
        ref_q.delete();
        mask_q.delete();
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_sf", a_sf, 0);
        chk("rst_bits", a_bits, 0);
        chk("rst_errs", b_errs, 0);
        chk("rst_resync", a_rs, 0);

        // Clean link, with a start pulse mid-run that must be ignored
        add(120, 8'h00, 0);
        run_case("clean", 100, 40);
        chk("clean_bits_exact", a_bits, 800);

        // Bit errors after sync
        add(SW, 8'h00, 0);
        add(10, 8'h03, 0);
        add(44, 8'h00, 0);
        run_case("biterr", 50, -1);
        chk("biterr_errs_exact", a_errs, 20);

        // Never syncs: every 4th word errored
        for (int i = 0; i < 80; i++) begin
            ref_q.push_back(8'($urandom));
            mask_q.push_back((i % 4 == 3) ? 8'h01 : 8'h00);
        end
        run_case("nosync", 100, -1);
        chk("nosync_sf_exact", b_sf, 1);

        // Saturation of the 8-bit instance
        add(SW, 8'h00, 0);
        add(44, 8'hFF, 0);
        run_case("sat", 40, -1);
        chk("sat_errs8_exact", b_errs, 255);

        // Window 0 behaves as a one-word window
        add(24, 8'h00, 0);
        run_case("win0", 0, -1);

        // Abort mid-MEASURE: the last fed word is still in flight and is dropped
        add(SW + 30, 8'h00, 0);
        start_run(100);
        feed(-1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check_results("abort", ref_q.size() - 1, 100, 1);
        chk("abort_bits_exact", a_bits, 29 * 8);
        feed(-1);
        repeat (3) @(negedge clk);
        chk("abort_hold_bits", a_bits, 29 * 8);
        chk("abort_hold_busy", a_busy, 0);
        ref_q.delete();
        mask_q.delete();

        // Abort has priority over start
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("abort_vs_start_busy", a_busy, 0);

`ifdef BER_RESYNC_EN
        // Four bad words mid-window force a resync; counting resumes afterwards
        add(SW, 8'h00, 0);
        add(10, 8'h00, 0);
        add(4, 8'hFF, 0);
        add(SW, 8'h00, 0);
        add(44, 8'h00, 0);
        run_case("resync", 50, -1);
        chk("resync_cnt_exact", b_rs, 1);
        chk("resync_bits_exact", a_bits, 400);
`endif

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            int win;
            win = $urandom_range(10, 60);
            add(SW, 8'h00, 0);
            add(win + 30, 8'h00, 1);
            run_case($sformatf("rand%0d", r), win, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
